// File: rtl/mux_n_reg.sv
// Registered N-channel selector with manual select (glitch-free switch via a blank cycle)
// and round-robin scan over the valid channels.

module mux_n_reg_chk #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned SEL_WIDTH = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic [SEL_WIDTH-1:0] cur_sel,
    input logic [SEL_WIDTH-1:0] sr,
    input logic                 bl,
    input logic                 mode
);

    // Pointer and granted channel must always name an existing channel.
    a_sr_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(sr) < CHANNELS);

    a_cur_sel_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(cur_sel) < CHANNELS);

    // The blank flag is only ever live in manual mode and lasts a single edge unless re-armed.
    a_bl_manual: assert property (@(posedge clk) disable iff (!rst_n)
        (mode && $past(mode)) |-> !bl);

endmodule

module mux_n_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned SEL_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       valid_in,
    input  logic [SEL_WIDTH-1:0]      sel,
    input  logic                      sel_load,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [SEL_WIDTH-1:0]      cur_sel,
    output logic                      sel_err
);

    logic [WIDTH-1:0]     out_r;
    logic                 out_valid_r;
    logic [SEL_WIDTH-1:0] cur_sel_r;
    logic                 sel_err_r;
    logic [SEL_WIDTH-1:0] sr_r;
    logic                 bl_r;

    logic [WIDTH-1:0]     out_nxt_s;
    logic                 out_valid_nxt_s;
    logic [SEL_WIDTH-1:0] cur_sel_nxt_s;
    logic                 sel_err_nxt_s;
    logic [SEL_WIDTH-1:0] sr_nxt_s;
    logic                 bl_nxt_s;

    logic                 sel_in_range_s;
    logic                 sel_ok_s;
    logic                 sel_bad_s;
    logic                 man_valid_s;
    logic [WIDTH-1:0]     man_data_s;
    logic                 rr_found_s;
    logic [SEL_WIDTH-1:0] rr_idx_s;
    logic [WIDTH-1:0]     rr_data_s;

    assign sel_in_range_s = (32'(sel) < CHANNELS);
    assign sel_ok_s       = sel_load & sel_in_range_s;
    assign sel_bad_s      = sel_load & ~sel_in_range_s;

    // Manual-mode source: data and valid of the channel named by the select register.
    always_comb begin
        man_valid_s = 1'b0;
        man_data_s  = {WIDTH{1'b0}};
        for (int c = 0; c < int'(CHANNELS); c++) begin
            man_valid_s = (SEL_WIDTH'(c) == sr_r) ? valid_in[c] : man_valid_s;
            man_data_s  = (SEL_WIDTH'(c) == sr_r) ? din[c*WIDTH +: WIDTH] : man_data_s;
        end
    end

    // Round-robin search: distance from SR is 1..CHANNELS, with SR itself ranked last.
    always_comb begin
        int unsigned raw_d;
        int unsigned dist_d;
        int unsigned best_d;
        rr_found_s = 1'b0;
        rr_idx_s   = sr_r;
        rr_data_s  = {WIDTH{1'b0}};
        best_d     = CHANNELS + 32'd1;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            raw_d  = 32'(c) + CHANNELS - 32'(sr_r);
            dist_d = (raw_d >= CHANNELS) ? (raw_d - CHANNELS) : raw_d;
            dist_d = (dist_d == 32'd0) ? CHANNELS : dist_d;
            if (valid_in[c] && (dist_d < best_d)) begin
                best_d     = dist_d;
                rr_found_s = 1'b1;
                rr_idx_s   = SEL_WIDTH'(c);
                rr_data_s  = din[c*WIDTH +: WIDTH];
            end else begin
                best_d = best_d;
            end
        end
    end

    // Next-state decision for select register, blank flag and registered outputs.
    always_comb begin
        out_nxt_s       = out_r;
        out_valid_nxt_s = 1'b0;
        cur_sel_nxt_s   = cur_sel_r;
        sel_err_nxt_s   = sel_bad_s;
        sr_nxt_s        = sr_r;
        bl_nxt_s        = 1'b0;
        if (!mode) begin
            // A real switch arms one blank edge; a pending blank is always consumed here.
            if (sel_ok_s && (sel != sr_r)) begin
                sr_nxt_s = sel;
                bl_nxt_s = 1'b1;
            end else begin
                bl_nxt_s = 1'b0;
            end
            if (bl_r) begin
                out_valid_nxt_s = 1'b0;
            end else if (man_valid_s) begin
                out_nxt_s       = man_data_s;
                out_valid_nxt_s = 1'b1;
                cur_sel_nxt_s   = sr_r;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else begin
            // A valid seed replaces this edge's grant; an out-of-range one only flags.
            if (sel_ok_s) begin
                sr_nxt_s = sel;
            end else if (rr_found_s) begin
                out_nxt_s       = rr_data_s;
                out_valid_nxt_s = 1'b1;
                cur_sel_nxt_s   = rr_idx_s;
                sr_nxt_s        = rr_idx_s;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            cur_sel_r   <= {SEL_WIDTH{1'b0}};
            sel_err_r   <= 1'b0;
            sr_r        <= {SEL_WIDTH{1'b0}};
            bl_r        <= 1'b0;
        end else begin
            out_r       <= out_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            cur_sel_r   <= cur_sel_nxt_s;
            sel_err_r   <= sel_err_nxt_s;
            sr_r        <= sr_nxt_s;
            bl_r        <= bl_nxt_s;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign cur_sel   = cur_sel_r;
    assign sel_err   = sel_err_r;

    mux_n_reg_chk #(
        .CHANNELS  (CHANNELS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .cur_sel (cur_sel_r),
        .sr      (sr_r),
        .bl      (bl_r),
        .mode    (mode)
    );

endmodule
